contador_monitor: RTL and testbench



---
 rtl/contador_monitor_pkg.sv | 17 +
 rtl/contador_monitor_predict.sv | 45 ++++
 rtl/contador_monitor.sv | 97 +++++++++
 tb/tb_contador_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_monitor_pkg.sv
// Shared definitions for the 32-bit counter and its passive monitor:
// mode encodings, monitor FSM states and the default data width.
package contador_defs;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] MODE_UP1  = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_DN3  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

endpackage

// File: rtl/contador_monitor_predict.sv
// Combinational prediction of the counter's next Q/rco/load from the
// previous cycle's sample; reusable by any counter scoreboard.
module contador_predict
  import contador_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             en_p,
  input  logic [1:0]       mode_p,
  input  logic [WIDTH-1:0] q_p,
  output logic [WIDTH-1:0] exp_q,
  output logic             exp_rco,
  output logic             exp_load,
  output logic             chk_q
);

  always_comb begin
    exp_q    = q_p;
    exp_rco  = 1'b0;
    exp_load = 1'b0;
    chk_q    = 1'b1;
    if (en_p) begin
      case (mode_p)
        MODE_UP1: begin
          exp_q   = q_p + WIDTH'(1);
          exp_rco = &q_p;
        end
        MODE_DN1: begin
          exp_q   = q_p - WIDTH'(1);
          exp_rco = (q_p == '0);
        end
        MODE_DN3: begin
          exp_q   = q_p - WIDTH'(3);
          exp_rco = (q_p < WIDTH'(3));
        end
        default: begin
          // Parallel load: the loaded value is unknown to the monitor.
          chk_q    = 1'b0;
          exp_load = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/contador_monitor.sv
// Passive checker for the 32-bit counter: predicts Q/rco/load one cycle
// ahead and flags mismatches. Define CONTADOR_MON_STICKY_EN for sticky err_*.
module contador_monitor
  import contador_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] Q,
  input  logic             rco,
  input  logic             load,
  output logic             err_q,
  output logic             err_rco,
  output logic             err_load,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] rco_count,
  output logic             synced
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state;
  logic             en_p;
  logic [1:0]       mode_p;
  logic [WIDTH-1:0] q_p;

  logic [WIDTH-1:0] exp_q;
  logic             exp_rco;
  logic             exp_load;
  logic             chk_q;
  logic             mis_q;
  logic             mis_rco;
  logic             mis_load;

  contador_predict #(.WIDTH(WIDTH)) u_predict (
    .en_p    (en_p),
    .mode_p  (mode_p),
    .q_p     (q_p),
    .exp_q   (exp_q),
    .exp_rco (exp_rco),
    .exp_load(exp_load),
    .chk_q   (chk_q)
  );

  // Case inequality so X/Z on the counter outputs reads as a mismatch.
  always_comb begin
    mis_q    = chk_q && (Q !== exp_q);
    mis_rco  = (rco !== exp_rco);
    mis_load = (load !== exp_load);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_UNSYNC;
      en_p      <= 1'b0;
      mode_p    <= MODE_UP1;
      q_p       <= '0;
      err_q     <= 1'b0;
      err_rco   <= 1'b0;
      err_load  <= 1'b0;
      err_count <= '0;
      rco_count <= '0;
      synced    <= 1'b0;
    end else begin
      en_p   <= enable;
      mode_p <= mode;
      q_p    <= Q;
      synced <= 1'b1;
      case (state)
        ST_UNSYNC: state <= ST_CHECK;
        default: begin
          state <= ST_CHECK;
`ifdef CONTADOR_MON_STICKY_EN
          err_q    <= err_q    | mis_q;
          err_rco  <= err_rco  | mis_rco;
          err_load <= err_load | mis_load;
`else
          err_q    <= mis_q;
          err_rco  <= mis_rco;
          err_load <= mis_load;
`endif
          if (mis_q || mis_rco || mis_load)
            err_count <= sat_inc(err_count);
          if (rco === 1'b1)
            rco_count <= sat_inc(rco_count);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_monitor.sv
// Bench for contador_monitor: directed scenarios plus random counter traffic
// with injected faults, checked against a cycle-level reference model.
module tb_contador_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] Q;
  logic        rco;
  logic        load;
  logic        err_q;
  logic        err_rco;
  logic        err_load;
  logic [15:0] err_count;
  logic [15:0] rco_count;
  logic        synced;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_sync;
  bit          p_en;
  logic [1:0]  p_mode;
  logic [31:0] p_q;
  bit          m_err_q, m_err_rco, m_err_load;
  int          m_err_cnt, m_rco_cnt;

  contador_monitor #(.WIDTH(32), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .Q        (Q),
    .rco      (rco),
    .load     (load),
    .err_q    (err_q),
    .err_rco  (err_rco),
    .err_load (err_load),
    .err_count(err_count),
    .rco_count(rco_count),
    .synced   (synced)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; p_en = 0; p_mode = 2'b00; p_q = 32'h0;
    m_err_q = 0; m_err_rco = 0; m_err_load = 0;
    m_err_cnt = 0; m_rco_cnt = 0;
  endtask

  // One clock edge of the monitor, from the counter contract in plain arithmetic.
  task automatic model_edge(input bit en, input logic [1:0] md, input logic [31:0] q,
                            input logic r, input logic l);
    logic [31:0] eq;
    bit er, el, cq, bq, br, bl;
    if (m_sync) begin
      eq = p_q; er = 0; el = 0; cq = 1;
      if (p_en) begin
        if (p_mode == 2'd0) begin eq = p_q + 32'd1; er = (p_q == 32'hFFFF_FFFF); end
        else if (p_mode == 2'd1) begin eq = p_q - 32'd1; er = (p_q == 32'd0); end
        else if (p_mode == 2'd2) begin eq = p_q - 32'd3; er = (p_q < 32'd3); end
        else begin cq = 0; el = 1; end
      end
      bq = cq && (q !== eq);
      br = (r !== er);
      bl = (l !== el);
`ifdef CONTADOR_MON_STICKY_EN
      m_err_q = m_err_q | bq; m_err_rco = m_err_rco | br; m_err_load = m_err_load | bl;
`else
      m_err_q = bq; m_err_rco = br; m_err_load = bl;
`endif
      if ((bq || br || bl) && m_err_cnt < 65535) m_err_cnt++;
      if (r === 1'b1 && m_rco_cnt < 65535) m_rco_cnt++;
    end
    m_sync = 1;
    p_en = en; p_mode = md; p_q = q;
  endtask

  task automatic compare_all();
    check_val("err_q", {31'b0, err_q}, {31'b0, m_err_q});
    check_val("err_rco", {31'b0, err_rco}, {31'b0, m_err_rco});
    check_val("err_load", {31'b0, err_load}, {31'b0, m_err_load});
    check_val("err_count", {16'b0, err_count}, m_err_cnt);
    check_val("rco_count", {16'b0, rco_count}, m_rco_cnt);
    check_val("synced", {31'b0, synced}, {31'b0, m_sync});
  endtask

  task automatic step(input bit en, input logic [1:0] md, input logic [31:0] q,
                      input logic r, input logic l);
    enable = en; mode = md; Q = q; rco = r; load = l;
    @(posedge clk);
    model_edge(en, md, q, r, l);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 0; mode = 2'b00; Q = 32'h0; rco = 0; load = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] cq;
    logic        cr, cl, fr, fl;
    logic [31:0] fq;
    bit          en;
    logic [1:0]  md;
    int          hi_cycles;

    // Scenario 1: wrap upward through zero
    do_reset();
    step(1, 2'b00, 32'hFFFF_FFFD, 0, 0);
    step(1, 2'b00, 32'hFFFF_FFFE, 0, 0);
    step(1, 2'b00, 32'hFFFF_FFFF, 0, 0);
    step(1, 2'b00, 32'h0000_0000, 1, 0);
    step(1, 2'b00, 32'h0000_0001, 0, 0);
    step(1, 2'b00, 32'h0000_0002, 0, 0);
    check_val("s1_rco_count", {16'b0, rco_count}, 32'd1);
    check_val("s1_err_count", {16'b0, err_count}, 32'd0);

    // Scenario 2: down-by-3 borrow, then a faulty Q
    do_reset();
    step(1, 2'b10, 32'd5, 0, 0);
    step(1, 2'b10, 32'd2, 0, 0);
    step(1, 2'b10, 32'hFFFF_FFFF, 1, 0);
    step(1, 2'b10, 32'hFFFF_FFFE, 0, 0);
    check_val("s2_err_q", {31'b0, err_q}, 32'd1);
    check_val("s2_err_count", {16'b0, err_count}, 32'd1);
    step(1, 2'b10, 32'hFFFF_FFFB, 0, 0);

    // Scenario 3: disabled counter, then a spurious rco
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 2'b00, 32'h1234, 0, 0);
    step(0, 2'b00, 32'h1234, 1, 0);
    check_val("s3_err_rco", {31'b0, err_rco}, 32'd1);
    check_val("s3_err_count", {16'b0, err_count}, 32'd1);
    check_val("s3_rco_count", {16'b0, rco_count}, 32'd1);
    step(0, 2'b00, 32'h1234, 0, 0);

    // Scenario 4: parallel load accepted, then a missing load indicator
    do_reset();
    step(1, 2'b11, 32'd10, 0, 0);
    step(1, 2'b01, 32'hA5A5_A5A5, 0, 1);
    step(1, 2'b01, 32'hA5A5_A5A4, 0, 0);
    check_val("s4_err_count_ok", {16'b0, err_count}, 32'd0);
    step(1, 2'b11, 32'hA5A5_A5A3, 0, 0);
    step(1, 2'b00, 32'h0BAD_0BAD, 0, 0);
    check_val("s4_err_load", {31'b0, err_load}, 32'd1);
    step(1, 2'b00, 32'h0BAD_0BAE, 0, 0);

    // Scenario 5: asynchronous reset with an error pending
    do_reset();
    step(1, 2'b00, 32'd0, 0, 0);
    step(1, 2'b00, 32'd7, 0, 0);
    check_val("s5_err_pending", {31'b0, err_q}, 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    step(1, 2'b00, 32'hDEAD_BEEF, 1, 1);
    check_val("s5_first_unchecked", {16'b0, err_count}, 32'd0);
    step(1, 2'b00, 32'hDEAD_BEF0, 0, 0);

    // Scenario 6: one Q mismatch followed by 20 clean cycles
    do_reset();
    step(1, 2'b00, 32'd100, 0, 0);
    step(1, 2'b00, 32'd200, 0, 0);
    hi_cycles = err_q ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 2'b00, 32'd200 + i, 0, 0);
      if (err_q) hi_cycles++;
    end
    check_val("s6_err_count", {16'b0, err_count}, 32'd1);
`ifdef CONTADOR_MON_STICKY_EN
    check_val("s6_err_q_cycles", hi_cycles, 32'd21);
`else
    check_val("s6_err_q_cycles", hi_cycles, 32'd1);
`endif

    // X on Q while checking
    do_reset();
    step(1, 2'b00, 32'd1, 0, 0);
    step(1, 2'b00, 32'hxxxx_xxxx, 0, 0);
    check_val("x_err_q", {31'b0, err_q}, 32'd1);

    // Random counter traffic with occasional injected faults
    do_reset();
    cq = $urandom; cr = 0; cl = 0;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) cq = {30'h3FFF_FFFF, 2'($urandom_range(0, 3))};
      else if ($urandom_range(0, 5) == 0) cq = 32'($urandom_range(0, 3));
      fq = cq; fr = cr; fl = cl;
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 2))
          0: fq = cq ^ (32'd1 << $urandom_range(0, 31));
          1: fr = ~cr;
          default: fl = ~cl;
        endcase
      end
      step(en, md, fq, fr, fl);
      cr = 0; cl = 0; cq = fq;
      if (en) begin
        case (md)
          2'b00: begin cr = (fq == 32'hFFFF_FFFF); cq = fq + 1; end
          2'b01: begin cr = (fq == 32'd0); cq = fq - 1; end
          2'b10: begin cr = (fq < 32'd3); cq = fq - 3; end
          default: begin cl = 1; cq = $urandom; end
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
